// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID->EX pipeline register with WB bypass, stall and flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int DW = 8,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic [DW-1:0] id_rs1_data,
    input  logic [DW-1:0] id_rs2_data,
    input  logic [DW-1:0] id_imm,
    input  logic          id_use_imm,
    input  logic          id_alu_sel,
    input  logic [RW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic          ex_sel,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_valid
);

    localparam logic [RW-1:0] C_R0 = '0;

    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [RW-1:0] r_rs1;
    logic [RW-1:0] r_rs2;
    logic          r_use_imm;
    logic          r_sel;
    logic [RW-1:0] r_rd;
    logic          r_rw;
    logic          r_valid;

    logic          w_hit_id_rs1;
    logic          w_hit_id_rs2;
    logic          w_hit_ex_rs1;
    logic          w_hit_ex_rs2;
    logic [DW-1:0] w_cap_a;
    logic [DW-1:0] w_cap_b;
    logic [DW-1:0] w_ex_a;
    logic [DW-1:0] w_ex_b;

    // r0 is hardwired zero, so it can never be a bypass source.
    assign w_hit_id_rs1 = wb_reg_write && (wb_rd == id_rs1) && (id_rs1 != C_R0);
    assign w_hit_id_rs2 = wb_reg_write && (wb_rd == id_rs2) && (id_rs2 != C_R0);
    assign w_hit_ex_rs1 = wb_reg_write && (wb_rd == r_rs1)  && (r_rs1  != C_R0);
    assign w_hit_ex_rs2 = wb_reg_write && (wb_rd == r_rs2)  && (r_rs2  != C_R0);

    assign w_cap_a = w_hit_id_rs1 ? wb_data : id_rs1_data;
    assign w_cap_b = id_use_imm ? id_imm : (w_hit_id_rs2 ? wb_data : id_rs2_data);

    assign w_ex_a = (r_valid && w_hit_ex_rs1) ? wb_data : r_a;
    assign w_ex_b = (r_valid && !r_use_imm && w_hit_ex_rs2) ? wb_data : r_b;

    assign ex_a         = w_ex_a;
    assign ex_b         = w_ex_b;
    assign ex_sel       = r_sel;
    assign ex_rd        = r_rd;
    assign ex_reg_write = r_rw && r_valid;
    assign ex_valid     = r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_use_imm <= 1'b0;
            r_sel     <= 1'b0;
            r_rd      <= '0;
            r_rw      <= 1'b0;
            r_valid   <= 1'b0;
        end else if (flush) begin
            r_a       <= '0;
            r_b       <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_use_imm <= 1'b0;
            r_sel     <= 1'b0;
            r_rd      <= '0;
            r_rw      <= 1'b0;
            r_valid   <= 1'b0;
        end else if (stall) begin
            // Latch the bypassed operands so they outlive the WB write.
            r_a <= w_ex_a;
            r_b <= w_ex_b;
        end else begin
            r_a       <= w_cap_a;
            r_b       <= w_cap_b;
            r_rs1     <= id_rs1;
            r_rs2     <= id_rs2;
            r_use_imm <= id_use_imm;
            r_sel     <= id_alu_sel;
            r_rd      <= id_rd;
            r_rw      <= id_reg_write && id_valid;
            r_valid   <= id_valid;
        end
    end

endmodule

`default_nettype wire
